vga_plot_arbiter: RTL
=====================

# vga_plot_arbiter

Shares the single pixel-write port of the 160x120 VGA frame-buffer adapter (x, y, color, plot) between three drawing requesters (maze/background repaint, player sprite, obstacle layer). Each requester submits a filled-rectangle command over a req/ack/done handshake. The arbiter grants requesters round-robin and rasters the granted rectangle at one pixel per clock. It sits between the game FSMs inside `system` and the adapter's `x`/`y`/`colour`/`plot` inputs.

## Interface
Parameters:
- `XW`, 8, x coordinate / width field bits
- `YW`, 7, y coordinate / height field bits
- `CW`, 3, color bits
- `XMAX`, 160, visible columns (clip bound)
- `YMAX`, 120, visible rows (clip bound)

Ports (requester i occupies slice i of each packed bus, i = 0..2):
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req`  in  3  command request, one bit per requester
- `req_x`  in  3*XW  rectangle origin x
- `req_y`  in  3*YW  rectangle origin y
- `req_w`  in  3*XW  width in pixels (0 = empty)
- `req_h`  in  3*YW  height in pixels (0 = empty)
- `req_color`  in  3*CW  fill color
- `ack`  out  3  one-cycle pulse: command latched
- `done`  out  3  one-cycle pulse: rectangle finished
- `busy`  out  1  high in DRAW and FIN
- `gnt_id`  out  2  index of the current/last grant
- `x`  out  XW  pixel x to adapter
- `y`  out  YW  pixel y to adapter
- `color`  out  CW  pixel color to adapter
- `plot`  out  1  pixel write strobe to adapter

## Operation
- States: IDLE, DRAW, FIN.
- All outputs are registered. Reset values: `ack`, `done`, `busy`, `plot`, `x`, `y`, `color`, `gnt_id` all 0; state IDLE; round-robin pointer set so requester 0 has highest priority.
- IDLE: if any `req` bit is high, pick the first set bit at or after (last grant + 1) mod 3. Latch that requester's x, y, w, h and color, and set `gnt_id`.
  - If w = 0 or h = 0, go to FIN.
  - Otherwise go to DRAW.
  - `ack[g]` pulses in the first cycle of the next state.
- Requester rules: hold `req` and the command fields stable until `ack`, then drop `req` or present the next command. A `req` dropped before `ack` is a protocol violation; the arbiter does not detect it.
- DRAW: emit pixels in raster order. x steps from x0 to x0+w-1; at the end of each row x returns to x0 and y increments. Each pixel takes one cycle with `plot` = 1, except pixels suppressed by clipping (see Configuration).
- After pixel (x0+w-1, y0+h-1), go to FIN.
- FIN: lasts one cycle. `done[g]` = 1, `plot` = 0, pointer set to g. Return to IDLE.
- Only one grant is outstanding at a time. `req` from other requesters is ignored until IDLE.
- Arithmetic: internal counters are XW/YW bits wide. Coordinate sums are computed one bit wider, and the output is the truncated low bits (wrap modulo 2^XW / 2^YW).
- If reset asserts mid-rectangle, the command is abandoned: no `done` pulse, and `plot` drops asynchronously.

## Timing
- `req` sampled high in IDLE at cycle N:
  - `ack` and the first pixel are in cycle N+1.
  - Pixels occupy cycles N+1 .. N+w*h.
  - `done` is in cycle N+w*h+1 (FIN).
  - Earliest next sample is at N+w*h+2 (IDLE).
- Empty command (w = 0 or h = 0): `ack` and `done` both in cycle N+1, no `plot`.
- Throughput is one pixel per clock. Overhead is two cycles per command (IDLE sample plus FIN).
- Simultaneous requests are granted strictly in rotation. Any requester holding `req` waits at most two other commands.

## Configuration
- `VGA_PLOT_CLIP_EN`, if defined:
  - A pixel whose unwrapped x ≥ XMAX or unwrapped y ≥ YMAX is emitted with `plot` = 0.
  - It still consumes its cycle, so timing is unchanged.
- If not defined: no clipping; every pixel gets `plot` = 1 with wrapped coordinates.

## Test plan
- Reset, then a single `req[1]` with x=10, y=20, w=3, h=2, color=5:
  - `ack[1]` in cycle N+1.
  - Pixels (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all color 5.
  - `done[1]` in cycle N+7, `gnt_id` = 1.
- All three `req` bits held continuously with 1x1 commands: grant order 0,1,2,0,1,2. Each `done` is followed two cycles later by the next `ack`.
- w=0, h=5 on requester 2: `ack[2]` and `done[2]` in the same cycle, `plot` never high.
- Clipping, x=158, y=119, w=4, h=2:
  - With `VGA_PLOT_CLIP_EN`: `plot` = 1 only for (158,119) and (159,119); 8 pixel cycles total.
  - Without it: all 8 plotted, x wraps at 256 only (x values 158..161).
- Assert `reset` during the 3rd pixel of a 4x4 rectangle:
  - `plot` goes 0 immediately, no `done`.
  - After release, `req[0]` and `req[2]` both high: requester 0 is granted first.
- `req[0]` raised in the FIN cycle of requester 1's command: `ack[0]` appears two cycles later; no pixel is lost or duplicated.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that rasters filled-rectangle commands from three requesters onto one pixel-write port.
// Optional build macro VGA_PLOT_CLIP_EN suppresses plot for pixels outside XMAX x YMAX.
module vga_plot_arbiter #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 3,
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [3*XW-1:0] req_x,
    input  logic [3*YW-1:0] req_y,
    input  logic [3*XW-1:0] req_w,
    input  logic [3*YW-1:0] req_h,
    input  logic [3*CW-1:0] req_color,
    output logic [2:0]      ack,
    output logic [2:0]      done,
    output logic            busy,
    output logic [1:0]      gnt_id,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic [CW-1:0]   color,
    output logic            plot
);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [XW-1:0] x0, w, cx;
    logic [YW-1:0] y0, h, cy;
    logic [CW-1:0] col;

    logic [1:0]    c0, c1, c2, sel;
    logic [XW-1:0] sx, sw, bx, ox, ncx, px;
    logic [YW-1:0] sy, sh, by, oy, ncy, py;
    logic [CW-1:0] sc;
    logic          last_col, last_row, vis;

    // Rotation order starts just after the last grant; later assignments win.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        c0  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        c1  = (c0  == 2'd2) ? 2'd0 : c0  + 2'd1;
        c2  = (c1  == 2'd2) ? 2'd0 : c1  + 2'd1;
        sel = c0;
        if (req[c2]) sel = c2;
        if (req[c1]) sel = c1;
        if (req[c0]) sel = c0;
    end

    assign sx = req_x[sel*XW +: XW];
    assign sy = req_y[sel*YW +: YW];
    assign sw = req_w[sel*XW +: XW];
    assign sh = req_h[sel*YW +: YW];
    assign sc = req_color[sel*CW +: CW];

    assign last_col = (cx == w - XW'(1));
    assign last_row = (cy == h - YW'(1));
    assign ncx      = last_col ? '0 : cx + XW'(1);
    assign ncy      = last_col ? cy + YW'(1) : cy;

    // In IDLE the first pixel is the origin of the incoming command.
    assign bx = (state == IDLE) ? sx : x0;
    assign by = (state == IDLE) ? sy : y0;
    assign ox = (state == IDLE) ? '0 : ncx;
    assign oy = (state == IDLE) ? '0 : ncy;

`ifdef VGA_PLOT_CLIP_EN
    localparam logic [XW:0] X_LIM = XMAX[XW:0];
    localparam logic [YW:0] Y_LIM = YMAX[YW:0];
    logic [XW:0] ux;
    logic [YW:0] uy;
    assign ux  = {1'b0, bx} + {1'b0, ox};
    assign uy  = {1'b0, by} + {1'b0, oy};
    assign vis = (ux < X_LIM) && (uy < Y_LIM);
    assign px  = ux[XW-1:0];
    assign py  = uy[YW-1:0];
`else
    assign vis = 1'b1;
    assign px  = bx + ox;
    assign py  = by + oy;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 2'd2;
            x0     <= '0;
            y0     <= '0;
            w      <= '0;
            h      <= '0;
            cx     <= '0;
            cy     <= '0;
            col    <= '0;
            ack    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            gnt_id <= 2'd0;
            x      <= '0;
            y      <= '0;
            color  <= '0;
            plot   <= 1'b0;
        end else begin
            ack  <= '0;
            done <= '0;
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        x0       <= sx;
                        y0       <= sy;
                        w        <= sw;
                        h        <= sh;
                        col      <= sc;
                        cx       <= '0;
                        cy       <= '0;
                        gnt_id   <= sel;
                        ack[sel] <= 1'b1;
                        busy     <= 1'b1;
                        if (sw == '0 || sh == '0) begin
                            state     <= FIN;
                            done[sel] <= 1'b1;
                        end else begin
                            state <= DRAW;
                            x     <= px;
                            y     <= py;
                            color <= sc;
                            plot  <= vis;
                        end
                    end
                end
                DRAW: begin
                    if (last_col && last_row) begin
                        state        <= FIN;
                        done[gnt_id] <= 1'b1;
                    end else begin
                        cx    <= ncx;
                        cy    <= ncy;
                        x     <= px;
                        y     <= py;
                        color <= col;
                        plot  <= vis;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= gnt_id;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
